// File: rtl/ula_result_buffer.sv
// rtl/ula_result_buffer.sv - result FIFO between the ALU and its downstream consumer
//
// Captures every ALU result strobed on ula_valid into a DEPTH-entry FIFO and
// presents the head entry first-word fall-through on a valid/ready pair.
// The ALU cannot be stalled, so a result arriving while the FIFO is full and
// not being drained the same cycle is dropped and recorded in sticky status.
//
// Ports:
//   clk_ula    in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   ula_valid  in   one-cycle result strobe from the ALU
//   ula_data   in   ALU result, sampled when ula_valid=1
//   res_valid  out  head entry available (!empty)
//   res_data   out  head entry, 0 while empty
//   res_ready  in   consumer accepts the head entry this cycle
//   count      out  stored entries, 0..DEPTH
//   empty      out  count==0
//   full       out  count==DEPTH
//   overflow   out  sticky: at least one result dropped
//   drop_cnt   out  dropped results, saturating at 255
//   ovf_clr    in   synchronous clear of overflow/drop_cnt

module ula_result_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_ula,
  input  logic              rst,
  input  logic              ula_valid,
  input  logic [DATA_W-1:0] ula_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  input  logic              ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [CNT_W-1:0]  cnt;
  logic              push;
  logic              pop;
  logic              drop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_FULL);
  assign res_valid = !empty;
  assign count     = cnt;

  // A pop frees the head slot at the same edge, so a full FIFO can still
  // accept a result when the consumer drains in that cycle.
  assign pop  = res_valid & res_ready;
  assign push = ula_valid & (!full | pop);
  assign drop = ula_valid & full & !pop;

  // Stale array contents are masked so nothing leaks out while empty.
  assign res_data = empty ? '0 : mem[rp];

  // Storage is not reset; only pointers and occupancy define valid data.
  always_ff @(posedge clk_ula) begin
    if (push) begin
      mem[wp] <= ula_data;
    end
  end

  always_ff @(posedge clk_ula or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        wp <= wp + PTR_W'(1);
      end
      if (pop) begin
        rp <= rp + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins: the cleared count restarts at 1.
  always_ff @(posedge clk_ula or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_ula_result_buffer.sv
// tb/tb_ula_result_buffer.sv - scoreboard bench for ula_result_buffer

module tb_ula_result_buffer;

  logic        clk_ula;
  logic        rst;
  logic        ula_valid;
  logic [31:0] ula_data;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        ovf_clr;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  ula_result_buffer #(.DATA_W(32), .DEPTH(4)) dut (
    .clk_ula   (clk_ula),
    .rst       (rst),
    .ula_valid (ula_valid),
    .ula_data  (ula_data),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .ovf_clr   (ovf_clr)
  );

  initial clk_ula = 1'b0;
  always #5 clk_ula = ~clk_ula;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; acc queues the value as an expected output.
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic c, input bit acc);
    ula_valid = v;
    ula_data  = d;
    res_ready = r;
    ovf_clr   = c;
    if (acc) exp_q.push_back(d);
    @(posedge clk_ula);
    #1;
    ula_valid = 1'b0;
    ula_data  = 32'h0;
    res_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  // Monitor: samples mid-cycle, compares every pop against the scoreboard
  // and checks that the head holds still across a stall.
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [31:0] exp_head;
  initial prev_stall = 1'b0;
  initial prev_data = 32'h0;

  always @(negedge clk_ula) begin
    if (prev_stall && res_valid) begin
      checks++;
      if (res_data !== prev_data) begin
        errors++;
        $display("FAIL stall_hold: got 0x%0h expected 0x%0h", res_data, prev_data);
      end
    end
    if (res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_order: got 0x%0h expected no output", res_data);
      end else begin
        exp_head = exp_q.pop_front();
        if (res_data !== exp_head) begin
          errors++;
          $display("FAIL pop_order: got 0x%0h expected 0x%0h", res_data, exp_head);
        end
      end
    end
    prev_stall = res_valid && !res_ready && rst;
    prev_data  = res_data;
  end

  logic [9:0] stall_pat;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    ula_valid = 1'b0;
    ula_data = 32'h0;
    res_ready = 1'b0;
    ovf_clr = 1'b0;
    #3;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk_ula);
    #2;
    rst = 1'b1;

    // Fill and drain
    step(1, 32'h11, 0, 0, 1);
    check("push_latency_head", res_data, 32'h11);
    step(1, 32'h22, 0, 0, 1);
    step(1, 32'h33, 0, 0, 1);
    step(1, 32'h44, 0, 0, 1);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    check("fill_head", res_data, 32'h11);

    // Overflow while full and stalled
    step(1, 32'h55, 0, 0, 0);
    step(1, 32'h66, 0, 0, 0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    check("ovf_head", res_data, 32'h11);
    check("ovf_count", 32'(count), 32'd4);
    step(0, 32'h0, 0, 1, 0);
    check("clr_flag", 32'(overflow), 32'd0);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);

    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_res_valid", 32'(res_valid), 32'd0);
    check("drain_res_data", res_data, 32'h0);
    step(0, 32'h0, 1, 0, 0);
    check("ready_when_empty_count", 32'(count), 32'd0);

    // Simultaneous push and pop at full
    for (int i = 0; i < 4; i++) step(1, 32'hA0 + 32'(i), 0, 0, 1);
    check("sim_full", 32'(full), 32'd1);
    step(1, 32'hB0, 1, 0, 1);
    check("sim_count", 32'(count), 32'd4);
    check("sim_no_ovf", 32'(overflow), 32'd0);
    check("sim_no_drop", 32'(drop_cnt), 32'd0);
    check("sim_head", res_data, 32'hA1);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);
    check("sim_drain_empty", 32'(empty), 32'd1);

    // Pointer wrap with stalls: occupancy peaks at 4, no drops
    stall_pat = 10'b1100110110;
    for (int i = 0; i < 10; i++) step(1, 32'hC0 + 32'(i), stall_pat[i], 0, 1);
    check("wrap_count", 32'(count), 32'd4);
    check("wrap_no_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 32'h0, logic'(i % 2), 0, 0);
    check("wrap_empty", 32'(empty), 32'd1);

    // Drop counter saturation and clear/drop race
    for (int i = 0; i < 4; i++) step(1, 32'hD0 + 32'(i), 0, 0, 1);
    for (int i = 0; i < 300; i++) step(1, 32'hEE, 0, 0, 0);
    check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    check("sat_overflow", 32'(overflow), 32'd1);
    step(1, 32'hEF, 0, 1, 0);
    check("race_drop_cnt", 32'(drop_cnt), 32'd1);
    check("race_overflow", 32'(overflow), 32'd1);
    check("race_head", res_data, 32'hD0);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 0, 1, 0);

    // Asynchronous reset mid-operation
    step(1, 32'hE0, 0, 0, 1);
    step(1, 32'hE1, 0, 0, 1);
    step(1, 32'hE2, 0, 0, 1);
    check("pre_rst_count", 32'(count), 32'd3);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_res_valid", 32'(res_valid), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    check("async_res_data", res_data, 32'h0);
    #3;
    rst = 1'b1;
    step(1, 32'hF0, 0, 0, 1);
    check("post_rst_head", res_data, 32'hF0);
    check("post_rst_count", 32'(count), 32'd1);
    step(0, 32'h0, 1, 0, 0);
    check("final_empty", 32'(empty), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk_ula);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_result_buffer.md
# ula_result_buffer

Output-side buffer for the ALU/register-bank block: captures every result the ALU presents on its result-valid strobe and holds it in a small FIFO. A downstream consumer drains the FIFO through a valid/ready handshake. The ALU has no backpressure input, so a result that arrives while the buffer cannot take it is dropped and recorded in sticky status. Sits directly downstream of the ALU's `data_out`/`valid_out` pair.

## Interface
Parameters:
- DATA_W, 32, result width; matches the ALU result bus.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk_ula  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ula_valid  input  1  one-cycle strobe; connect to the ALU `valid_out`.
- ula_data  input  DATA_W  result; connect to the ALU `data_out`; sampled only when `ula_valid`=1.
- res_valid  output  1  head entry available.
- res_data  output  DATA_W  head entry.
- res_ready  input  1  consumer accepts the head entry this cycle.
- count  output  CNT_W  number of stored entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; at least one result was dropped.
- drop_cnt  output  8  number of dropped results; saturates at 255.
- ovf_clr  input  1  synchronous clear of `overflow` and `drop_cnt`.

## Operation
- Storage: DEPTH×DATA_W array, write pointer `wp`, read pointer `rp`, and occupancy `count`. The pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Pop: `pop = res_valid & res_ready`. On a pop, `rp` increments.
- Push: `push = ula_valid & (!full | pop)`. On a push, `ula_data` is written at `wp` and `wp` increments.
  - At full, a push is accepted only when a pop happens in the same cycle.
- Drop: `drop = ula_valid & full & !pop`.
  - Storage, pointers and count are unchanged.
  - `overflow` is set to 1.
  - `drop_cnt` increments, saturating at 255.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Status outputs:
  - `empty`, `full` and `res_valid` (= !empty) are decoded combinationally from the registered `count`.
- Output data:
  - `res_data` = `mem[rp]` when not empty; 0 when empty.
  - The output is first-word fall-through; no extra output register.
- Clear:
  - `ovf_clr` alone: `overflow` <= 0 and `drop_cnt` <= 0.
  - `ovf_clr` in the same cycle as a drop: the drop wins, giving `overflow`=1 and `drop_cnt`=1.
- Handshake rules:
  - `res_data` must stay stable while `res_valid`=1 and `res_ready`=0.
  - `res_ready` asserted while empty has no effect.
- Reset (asserted, async):
  - `count`=0, `wp`=`rp`=0.
  - Outputs: `res_valid`=0, `res_data`=0, `empty`=1, `full`=0, `overflow`=0, `drop_cnt`=0.
  - Reset mid-operation discards all stored entries.
  - Array contents need not be reset, but must never be visible while empty.

## Timing
- Latency from push to head: a push into an empty FIFO at edge N makes `res_valid`=1 with that data after edge N (visible in cycle N+1).
- Pop: the pop takes effect at the edge where `res_valid & res_ready`=1; the next entry, or empty, appears in the following cycle.
- Throughput: one push and one pop per cycle are sustained at any occupancy, including full.
- Status timing:
  - `full`, `empty` and `count` reflect state after the last edge.
  - `overflow` and `drop_cnt` update at the edge of the dropping cycle.
- Reset behaviour:
  - Outputs take their reset values immediately on assertion of `rst`, independent of the clock.
  - Deassertion is synchronised externally; the block takes no action on the first edge after release beyond normal operation.

## Test plan
- Fill and drain: reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles with `res_ready`=0 → `full`=1, `count`=4. Then hold `res_ready`=1 → outputs 0x11,0x22,0x33,0x44 in order, then `empty`=1 and `res_data`=0.
- Overflow: full with `res_ready`=0, push 0x55 and 0x66 → both dropped, `overflow`=1, `drop_cnt`=2, head still 0x11. Pulse `ovf_clr` → `overflow`=0, `drop_cnt`=0.
- Simultaneous push and pop at full: full with 0xA0..0xA3, push 0xB0 with `res_ready`=1 → no drop, `count` stays 4. Drained order is 0xA1,0xA2,0xA3,0xB0.
- Pointer wrap and stall: run 10 push/pop cycles with random `res_ready` gaps → output sequence equals input sequence, and `res_data` is held stable during every stall.
- Saturation and clear race: 300 drops → `drop_cnt`=255. Then `ovf_clr` in the same cycle as a drop → `drop_cnt`=1, `overflow`=1.
- Async reset mid-operation: `count`=3, assert `rst` between clock edges → `res_valid`=0, `count`=0, `empty`=1 immediately. After release, the first push appears as the head.
